// File: rtl/hs_tx_sched.sv
// Paces producer words into the fast-side handshake transmitter: small FIFO in, one-cycle launch pulses out.
// Optional req/ack watchdog enabled by defining HS_TX_SCHED_TIMEOUT_EN.
module hs_tx_sched #(
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int GUARD   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                         t_clk,
  input  logic                         t_rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DW-1:0]                s_data,
  output logic                         hs_valid,
  output logic [DW-1:0]                hs_data,
  input  logic                         hs_req,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_HI, S_WAIT_LO, S_GUARD} state_t;

  state_t            state_reg, state_next;
  logic [DW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic [GW-1:0]     guard_cnt_reg, guard_cnt_next;
  logic              hs_valid_reg, hs_valid_next;
  logic [DW-1:0]     hs_data_reg;
  logic              push, pop;
  logic              tmo_hit;
  logic              err_reg;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GUARD < 1 || TIMEOUT < 1) begin : g_param_check
    $error("hs_tx_sched: illegal parameter set");
  end

  // FIFO: pop only looks at registered level, so a fresh word waits one cycle.
  assign s_ready = (level_reg != LW'(DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = (state_reg == S_IDLE) && (level_reg != '0);

  always_ff @(posedge t_clk) begin
    if (push) mem[wr_ptr_reg] <= s_data;
  end

  always_ff @(posedge t_clk or negedge t_rst_n) begin
    if (!t_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge t_clk or negedge t_rst_n) begin
    if (!t_rst_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // A req edge observed in WAIT_HI/WAIT_LO always beats a simultaneous watchdog expiry.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (level_reg != '0) state_next = S_LAUNCH;
      S_LAUNCH:  state_next = S_WAIT_HI;
      S_WAIT_HI: begin
        if (hs_req)       state_next = S_WAIT_LO;
        else if (tmo_hit) state_next = S_GUARD;
      end
      S_WAIT_LO: if (!hs_req || tmo_hit) state_next = S_GUARD;
      S_GUARD:   if (guard_cnt_reg == '0) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    hs_valid_next  = (state_reg == S_LAUNCH);
    guard_cnt_next = guard_cnt_reg;
    if (state_reg != S_GUARD && state_next == S_GUARD)
      guard_cnt_next = GW'(GUARD - 1);
    else if (state_reg == S_GUARD && guard_cnt_reg != '0)
      guard_cnt_next = guard_cnt_reg - GW'(1);
  end

  always_ff @(posedge t_clk or negedge t_rst_n) begin
    if (!t_rst_n) begin
      hs_valid_reg  <= 1'b0;
      hs_data_reg   <= '0;
      guard_cnt_reg <= '0;
    end else begin
      hs_valid_reg  <= hs_valid_next;
      guard_cnt_reg <= guard_cnt_next;
      if (pop) hs_data_reg <= mem[rd_ptr_reg];
    end
  end

`ifdef HS_TX_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt_reg;
  logic          waiting;
  logic          tmo_fire;

  assign waiting  = (state_reg == S_WAIT_HI) || (state_reg == S_WAIT_LO);
  assign tmo_hit  = waiting && (tmo_cnt_reg == TW'(TIMEOUT - 1));
  assign tmo_fire = tmo_hit && (hs_req == (state_reg == S_WAIT_LO));

  always_ff @(posedge t_clk or negedge t_rst_n) begin
    if (!t_rst_n) begin
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (state_next != state_reg) tmo_cnt_reg <= '0;
      else if (waiting)            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
      if (tmo_fire) err_reg <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err_reg = 1'b0;
`endif

  assign hs_valid = hs_valid_reg;
  assign hs_data  = hs_data_reg;
  assign level    = level_reg;
  assign busy     = (state_reg != S_IDLE) || (level_reg != '0);
  assign err      = err_reg;

endmodule

// File: tb/tb_hs_tx_sched.sv
// Randomized bench for hs_tx_sched: a timestamp-based model predicts pops, launches and guard release.
module tb_hs_tx_sched;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int GUARD = 8;
`ifdef HS_TX_SCHED_TIMEOUT_EN
  localparam int TIMEOUT = 16;
  localparam bit TMO_EN  = 1'b1;
`else
  localparam int TIMEOUT = 1024;
  localparam bit TMO_EN  = 1'b0;
`endif
  localparam int LW = $clog2(DEPTH + 1);

  logic          t_clk = 1'b0;
  logic          t_rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          hs_valid;
  logic [DW-1:0] hs_data;
  logic          hs_req;
  logic          busy;
  logic [LW-1:0] level;
  logic          err;

  logic tx_req, stray_req;
  bit   tx_early, tx_mute;
  int   tx_dwell_fix;

  int vectors = 0;
  int miscompares = 0;

  assign hs_req = tx_req | stray_req;
  always #5 t_clk = ~t_clk;

  hs_tx_sched #(.DW(DW), .DEPTH(DEPTH), .GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut (
    .t_clk(t_clk), .t_rst_n(t_rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .hs_valid(hs_valid), .hs_data(hs_data), .hs_req(hs_req), .busy(busy), .level(level), .err(err)
  );

  // Reference model: words waiting (with push edge), in-flight word and earliest edge a pop may happen.
  logic [DW-1:0] q_word[$];
  int            q_edge[$];
  bit            m_inflight, m_hi_seen, m_err;
  int            m_launch, m_entry, m_next_pop;
  logic [DW-1:0] m_data;
  int            k;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  task automatic model_reset();
    q_word.delete();
    q_edge.delete();
    m_inflight = 1'b0; m_hi_seen = 1'b0; m_err = 1'b0;
    m_launch = -10; m_entry = -10; m_next_pop = 0; m_data = '0;
  endtask

  task automatic retire(input int e, input bit timed_out);
    m_inflight = 1'b0;
    m_next_pop = e + GUARD + 1;
    if (timed_out) m_err = 1'b1;
  endtask

  // Advance the model across clock edge e using the inputs presented before that edge.
  task automatic step(input int e);
    int sz;
    sz = q_word.size();
    if (m_inflight && e > m_launch) begin
      if (!m_hi_seen) begin
        if (hs_req) begin m_hi_seen = 1'b1; m_entry = e; end
        else if (TMO_EN && e == m_entry + TIMEOUT) retire(e, 1'b1);
      end else begin
        if (!hs_req) retire(e, 1'b0);
        else if (TMO_EN && e == m_entry + TIMEOUT) retire(e, 1'b1);
      end
    end
    if (!m_inflight && e >= m_next_pop && sz > 0 && q_edge[0] < e) begin
      m_data     = q_word.pop_front();
      void'(q_edge.pop_front());
      m_inflight = 1'b1;
      m_hi_seen  = 1'b0;
      m_launch   = e + 1;
      m_entry    = e + 1;
    end
    if (s_valid && sz != DEPTH) begin
      q_word.push_back(s_data);
      q_edge.push_back(e);
    end
  endtask

  // Monitor / scoreboard: samples mid low-phase, compares every output against the model.
  initial begin
    k = 0;
    model_reset();
    forever begin
      @(negedge t_clk);
      #2;
      if (!t_rst_n) begin
        model_reset();
        check("rst_hs_valid", 64'(hs_valid), 64'(0));
        check("rst_hs_data",  64'(hs_data),  64'(0));
        check("rst_level",    64'(level),    64'(0));
        check("rst_s_ready",  64'(s_ready),  64'(1));
        check("rst_busy",     64'(busy),     64'(0));
        check("rst_err",      64'(err),      64'(0));
      end else begin
        if (hs_valid) $display("launch word 0x%08h at cycle %0d", hs_data, k);
        check("hs_valid", 64'(hs_valid), 64'(m_inflight && k == m_launch));
        check("hs_data",  64'(hs_data),  64'(m_data));
        check("level",    64'(level),    64'(q_word.size()));
        check("s_ready",  64'(s_ready),  64'(q_word.size() != DEPTH));
        check("busy",     64'(busy),     64'(m_inflight || q_word.size() != 0 || (k + 1) < m_next_pop));
        check("err",      64'(err),      64'(m_err));
        step(k + 1);
      end
      k++;
    end
  end

  // Transmitter model: answers each launch with a req pulse after a short random delay.
  initial begin
    int d, dw;
    tx_req = 1'b0;
    forever begin
      @(negedge t_clk);
      if (hs_valid && !tx_mute) begin
        d  = tx_early ? 0 : int'($urandom_range(0, 3));
        dw = (tx_dwell_fix > 0) ? tx_dwell_fix : int'($urandom_range(1, 6));
        repeat (d) @(negedge t_clk);
        tx_req = 1'b1;
        repeat (dw) @(negedge t_clk);
        tx_req = 1'b0;
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] w);
    int n;
    n = 0;
    @(negedge t_clk);
    s_valid = 1'b1;
    s_data  = w;
    #1;
    while (!s_ready && n < 300) begin
      @(negedge t_clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      vectors++; miscompares++;
      $display("FAIL push_accept: s_ready=%0b for word 0x%0h after %0d cycles, expected 1", s_ready, w, n);
      s_valid = 1'b0;
    end
  endtask

  task automatic release_s();
    @(negedge t_clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    @(negedge t_clk);
    #3;
    while ((busy || tx_req) && n < limit) begin
      @(negedge t_clk);
      #3;
      n++;
    end
    if (n >= limit) begin
      vectors++; miscompares++;
      $display("FAIL wait_idle: busy=%0b tx_req=%0b after %0d cycles, expected 0", busy, tx_req, limit);
    end
  endtask

  task automatic wait_tx_req(input logic lvl, input int limit);
    int n;
    n = 0;
    while (tx_req !== lvl && n < limit) begin
      @(negedge t_clk);
      n++;
    end
    if (n >= limit) begin
      vectors++; miscompares++;
      $display("FAIL wait_tx_req: tx_req=%0b after %0d cycles, expected %0b", tx_req, limit, lvl);
    end
  endtask

  initial begin
    int gap;
    t_rst_n = 1'b0; s_valid = 1'b0; s_data = '0; stray_req = 1'b0;
    tx_early = 1'b0; tx_mute = 1'b0; tx_dwell_fix = 0;
    repeat (3) @(negedge t_clk);
    t_rst_n = 1'b1;

    push_word(32'hA5A5_0001);
    release_s();
    wait_idle(200);

    tx_dwell_fix = 20;
    for (int i = 0; i < 6; i++) push_word(32'h10 + 32'(i));
    release_s();
    wait_idle(1500);
    tx_dwell_fix = 0;

    tx_early = 1'b1;
    push_word(32'hE1);
    push_word(32'hE2);
    release_s();
    wait_idle(300);
    tx_early = 1'b0;

    @(negedge t_clk);
    stray_req = 1'b1;
    repeat (3) @(negedge t_clk);
    stray_req = 1'b0;
    repeat (4) @(negedge t_clk);

    tx_dwell_fix = 20;
    push_word(32'h51);
    push_word(32'h52);
    push_word(32'h53);
    release_s();
    wait_tx_req(1'b1, 50);
    repeat (3) @(negedge t_clk);
    t_rst_n = 1'b0;
    repeat (2) @(negedge t_clk);
    t_rst_n = 1'b1;
    wait_tx_req(1'b0, 50);
    tx_dwell_fix = 0;
    push_word(32'h77);
    release_s();
    wait_idle(200);

    for (int i = 0; i < 40; i++) begin
      push_word($urandom);
      gap = int'($urandom_range(0, 4));
      if (gap > 0) begin
        release_s();
        repeat (gap - 1) @(negedge t_clk);
      end
    end
    release_s();
    wait_idle(3000);

`ifdef HS_TX_SCHED_TIMEOUT_EN
    tx_mute = 1'b1;
    push_word(32'h1);
    push_word(32'h2);
    release_s();
    wait_idle(300);
    tx_mute = 1'b0;
    push_word(32'h3);
    release_s();
    wait_idle(200);
`endif

    repeat (4) @(negedge t_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "global timeout");
  end

endmodule
